sample_store_player: RTL and testbench
======================================

Name: sample_store_player

Overview:
- Downstream consumer of the write-address sequencer.
- Captures each 16-bit sample strobed by `write_ready` into an internal RAM at the sequencer's address, widened to signed 24-bit by appending SHIFT zero LSBs.
- A playback FSM streams a requested address window back out over a valid/ready interface to the modulator/transmit path.

Parameters:
- ADDR_BITS, 8, RAM index width; DEPTH = 2^ADDR_BITS entries.
- SHIFT, 8, zero LSBs appended to `data_in`; stored word width is 16+SHIFT (24 at default).

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- write_ready  input  1  write strobe, synchronous to clk; a write occurs on its rising edge
- address  input  16  write address from sequencer; only [ADDR_BITS-1:0] used
- data_in  input  16  signed sample to store
- start  input  1  playback request, sampled in IDLE only
- rd_base  input  ADDR_BITS  first RAM index to play
- rd_len  input  ADDR_BITS+1  number of samples to play
- out_ready  input  1  downstream accepts sample_out
- sample_out  output  16+SHIFT  signed stored sample being presented
- out_valid  output  1  sample_out valid
- busy  output  1  playback FSM not in IDLE
- done  output  1  one-cycle pulse at end of playback
- wr_count  output  ADDR_BITS+1  writes accepted since reset, saturating

Behaviour:
- Reset values:
  - sample_out=0, out_valid=0, busy=0, done=0, wr_count=0.
  - write-edge register=0; FSM=IDLE; internal pointer and remaining count = 0.
  - RAM contents are not reset.
- Write side:
  - Edge detect: wr_q <= write_ready each cycle; a write fires when write_ready=1 and wr_q=0.
  - A level held high for N cycles gives exactly one write.
  - On a write, RAM[address[ADDR_BITS-1:0]] <= {data_in, SHIFT'b0}; upper address bits are ignored (aliasing is allowed).
  - wr_count += 1 per write and saturates at DEPTH.
- FSM states: IDLE, FETCH, PRESENT, DONE.
  - IDLE:
    - On start=1 with rd_len=0: go to DONE.
    - On start=1 with rd_len≠0: latch ptr=rd_base and rem=min(rd_len, DEPTH), then go to FETCH.
    - start is ignored in every other state.
  - FETCH: issue a synchronous RAM read at ptr; next cycle go to PRESENT with sample_out=read data and out_valid=1.
  - PRESENT:
    - sample_out and out_valid hold stable while out_ready=0.
    - On out_ready=1 (transfer): out_valid drops the next cycle.
    - If rem=1, go to DONE.
    - Otherwise rem-=1, ptr=(ptr+1) mod DEPTH, go to FETCH.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
  - busy = (state≠IDLE).
  - Throughput is one sample per 2 cycles when out_ready is held high.
  - Latency: start accepted at cycle t → out_valid=1 at t+2.
- Wrap-around: ptr wraps from DEPTH-1 to 0 inside a window.
- Write/read collision: a write to the same index in the same cycle as a FETCH read returns the old data (read-first). The new data is visible to later reads.
- Writes proceed independently of FSM state; playback never blocks writes.
- Reset asserted mid-playback:
  - FSM returns to IDLE immediately and out_valid/done go to 0.
  - No partial transfer completes.
  - RAM is retained.

Test Plan:
- Write then play one sample:
  - Stimulus: reset; pulse write_ready with address=16'h0105, data_in=16'h1234; then start with rd_base=5, rd_len=1.
  - Required: wr_count=1; out_valid at start+2 with sample_out=24'h123400; done pulses once after the handshake.
- Sign and hold-high:
  - Stimulus: data_in=16'hFFFF at address 0, write_ready held high 4 cycles.
  - Required: exactly one write, wr_count=1; playback gives 24'hFFFF00 (negative).
- Backpressure and wrap:
  - Stimulus: write 16'h0001..16'h0003 to indices 254, 255, 0; start with rd_base=254, rd_len=3; out_ready low for 3 cycles on the 2nd sample.
  - Required: outputs in order 24'h000100, 24'h000200, 24'h000300; sample_out stable during the stall.
- Boundary requests:
  - Stimulus: start with rd_len=0; separately, start while busy.
  - Required: rd_len=0 gives done one cycle later with no out_valid; start while busy is ignored and does not alter the window.
- Collision and saturation:
  - Stimulus: write index 7 in the same cycle the FSM fetches index 7; separately, perform 300 writes.
  - Required: the collision read returns the old value; wr_count stops at 256.
- Reset mid-playback:
  - Stimulus: assert reset while in PRESENT.
  - Required: out_valid=0, busy=0, done=0 immediately; after release, replaying returns the pre-reset RAM data.

Source files
------------

// File: rtl/sample_store_player.sv
// sample_store_player
//   Captures 16-bit samples from the write-address sequencer into a local RAM.
//   Each sample is widened to a signed word by appending SHIFT zero LSBs.
//   A playback FSM streams a requested address window back out over a
//   valid/ready interface.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   write_ready write strobe; one write per rising edge of this level
//   address     write address; only [ADDR_BITS-1:0] is used
//   data_in     signed sample to store
//   start       playback request, honoured only while idle
//   rd_base     first RAM index of the playback window
//   rd_len      number of samples to play (clamped to DEPTH)
//   out_ready   downstream accepts sample_out
//   sample_out  signed stored sample being presented
//   out_valid   sample_out is valid
//   busy        playback in progress
//   done        one-cycle pulse at the end of playback
//   wr_count    writes accepted since reset, saturating at DEPTH
module sample_store_player #(
  parameter int ADDR_BITS = 8,
  parameter int SHIFT     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        write_ready,
  input  logic [15:0]                 address,
  input  logic signed [15:0]          data_in,
  input  logic                        start,
  input  logic [ADDR_BITS-1:0]        rd_base,
  input  logic [ADDR_BITS:0]          rd_len,
  input  logic                        out_ready,
  output logic signed [15+SHIFT:0]    sample_out,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_BITS:0]          wr_count
);

  localparam int                 DEPTH   = 1 << ADDR_BITS;
  localparam int                 WORD_W  = 16 + SHIFT;
  localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] ONE_C   = (ADDR_BITS+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_t;

  function automatic logic signed [WORD_W-1:0] widen(input logic signed [15:0] s);
    return {s, {SHIFT{1'b0}}};
  endfunction

  function automatic logic [ADDR_BITS:0] clamp_len(input logic [ADDR_BITS:0] len);
    return (len > DEPTH_C) ? DEPTH_C : len;
  endfunction

  logic                     wr_q;
  logic                     wr_fire;
  logic [ADDR_BITS:0]       wr_count_q;
  logic [ADDR_BITS:0]       wr_count_d;
  logic signed [WORD_W-1:0] mem [DEPTH];

  state_t                   state_q;
  logic [ADDR_BITS-1:0]     ptr_q;
  logic [ADDR_BITS:0]       rem_q;
  logic signed [WORD_W-1:0] sample_q;
  logic                     out_valid_q;
  logic                     done_q;

  // Upper sequencer address bits alias onto the RAM and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[15:ADDR_BITS];

  // Write side: rising-edge detect so a held strobe produces a single write.
  always_comb begin
    wr_fire    = write_ready & ~wr_q;
    wr_count_d = wr_count_q;
    if (wr_fire && (wr_count_q != DEPTH_C))
      wr_count_d = wr_count_q + ONE_C;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q       <= 1'b0;
      wr_count_q <= '0;
    end else begin
      wr_q       <= write_ready;
      wr_count_q <= wr_count_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[address[ADDR_BITS-1:0]] <= widen(data_in);
  end

  // Playback FSM. The FETCH read samples mem with the pre-edge contents, so a
  // same-cycle write to the fetched index returns the old word (read-first).
  // done is set on entry to DONE and cleared by default, so it is high only
  // for the single cycle spent in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      sample_q    <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (rd_len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              ptr_q   <= rd_base;
              rem_q   <= clamp_len(rd_len);
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          sample_q    <= mem[ptr_q];
          out_valid_q <= 1'b1;
          state_q     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (rem_q == ONE_C) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              rem_q   <= rem_q - ONE_C;
              ptr_q   <= ptr_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sample_out = sample_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_sample_store_player.sv
// tb_sample_store_player
//   Drives sample_store_player with directed and randomized writes/playbacks
//   and compares every output against a behavioural model: a 256-entry shadow
//   memory, a saturating write counter, and an expected-sample queue per window.
module tb_sample_store_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_ready;
  logic [15:0] address;
  logic [15:0] data_in;
  logic        start;
  logic [7:0]  rd_base;
  logic [8:0]  rd_len;
  logic        out_ready;
  logic [23:0] sample_out;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic [8:0]  wr_count;

  int checks = 0;
  int errors = 0;

  logic [23:0] mem_m [256];
  int          cnt_m;

  sample_store_player #(.ADDR_BITS(8), .SHIFT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .write_ready (write_ready),
    .address     (address),
    .data_in     (data_in),
    .start       (start),
    .rd_base     (rd_base),
    .rd_len      (rd_len),
    .out_ready   (out_ready),
    .sample_out  (sample_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // All tasks below are entered and left at a falling clock edge.
  task automatic do_reset();
    reset       = 1'b1;
    write_ready = 1'b0;
    start       = 1'b0;
    out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt_m = 0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input int hold);
    write_ready = 1'b1;
    address     = a;
    data_in     = d;
    repeat (hold) @(negedge clk);
    write_ready = 1'b0;
    @(negedge clk);
    mem_m[a[7:0]] = {d, 8'h00};
    if (cnt_m < 256) cnt_m++;
  endtask

  // Plays window [base, base+len) and checks ordering, latency, stall
  // stability, valid drop, done pulse. poke issues a start while busy;
  // coll writes cdata to index base in the same cycle as the first fetch.
  task automatic play(input logic [7:0] base, input logic [8:0] len,
                      input int max_stall, input int stall_at, input int stall_len,
                      input bit poke, input bit coll, input logic [15:0] cdata);
    logic [23:0] exp_q[$];
    logic [23:0] held;
    int          n;
    int          stall;
    int          w;
    n = (len > 9'd256) ? 256 : int'(len);
    for (int i = 0; i < n; i++) exp_q.push_back(mem_m[8'(int'(base) + i)]);
    rd_base = base;
    rd_len  = len;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      chk("len0_done", done, 1);
      chk("len0_valid", out_valid, 0);
      @(negedge clk);
      chk("len0_done_end", done, 0);
      chk("len0_idle", busy, 0);
      return;
    end
    chk("busy_after_start", busy, 1);
    chk("valid_in_fetch", out_valid, 0);
    if (coll) begin
      write_ready = 1'b1;
      address     = {8'h00, base};
      data_in     = cdata;
    end
    @(negedge clk);
    if (coll) begin
      write_ready = 1'b0;
      mem_m[base] = {cdata, 8'h00};
      if (cnt_m < 256) cnt_m++;
    end
    chk("latency_valid", out_valid, 1);
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!out_valid && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk("valid_wait", out_valid, 1);
      chk("sample", sample_out, exp_q[i]);
      stall = (i == stall_at) ? stall_len : int'($urandom_range(0, max_stall));
      if (poke && i == 0 && stall == 0) stall = 1;
      held = sample_out;
      for (int k = 0; k < stall; k++) begin
        if (poke && i == 0 && k == 0) begin
          start   = 1'b1;
          rd_base = 8'($urandom);
          rd_len  = 9'd1;
        end
        @(negedge clk);
        start = 1'b0;
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", sample_out, held);
        chk("stall_no_done", done, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("valid_drop", out_valid, 0);
      chk((i == n - 1) ? "done_pulse" : "no_early_done", done, (i == n - 1) ? 1 : 0);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] len;
    int         r;
    reset = 1'b1; write_ready = 1'b0; address = '0; data_in = '0;
    start = 1'b0; rd_base = '0; rd_len = '0; out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_sample", sample_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrcount", wr_count, 0);

    // Write then play one sample (upper address bits ignored).
    wr(16'h0105, 16'h1234, 1);
    chk("wrcount_one", wr_count, 1);
    chk("model_word", mem_m[5], 24'h123400);
    play(8'd5, 9'd1, 0, -1, 0, 1'b0, 1'b0, 16'h0);

    // Negative sample, strobe held high for 4 cycles.
    do_reset();
    wr(16'h0000, 16'hFFFF, 4);
    chk("hold_high_wrcount", wr_count, 1);
    play(8'd0, 9'd1, 0, -1, 0, 1'b0, 1'b0, 16'h0);
    chk("negative_msb", sample_out[23], 1);

    // Backpressure on the 2nd sample and wrap 255 -> 0.
    wr(16'd254, 16'h0001, 1);
    wr(16'd255, 16'h0002, 1);
    wr(16'd0,   16'h0003, 1);
    play(8'd254, 9'd3, 0, 1, 3, 1'b0, 1'b0, 16'h0);

    // Zero-length request and start while busy.
    play(8'd9, 9'd0, 0, -1, 0, 1'b0, 1'b0, 16'h0);
    play(8'd254, 9'd3, 1, 0, 2, 1'b1, 1'b0, 16'h0);

    // 300 writes: fill every index, then extra writes with aliasing addresses.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      wr({8'($urandom), (i < 256) ? 8'(i) : 8'($urandom)}, 16'($urandom), 1);
      if (i == 255) chk("wrcount_full", wr_count, 256);
    end
    chk("wrcount_saturated", wr_count, 256);
    chk("wrcount_model", wr_count, cnt_m);

    // Read-first collision at index 7, then the new data on a later read.
    play(8'd7, 9'd1, 0, -1, 0, 1'b0, 1'b1, 16'hBEEF);
    chk("collision_new_model", mem_m[7], 24'hBEEF00);
    play(8'd7, 9'd1, 0, -1, 0, 1'b0, 1'b0, 16'h0);

    // Randomized windows, interleaved with random writes.
    for (int it = 0; it < 16; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      len = 9'd0;
      else if (r == 1) len = 9'd300;
      else             len = 9'($urandom_range(1, 20));
      if ($urandom_range(0, 1) == 1) wr(16'($urandom), 16'($urandom), int'($urandom_range(1, 3)));
      play(8'($urandom), len, 2, -1, 0, 1'b0, 1'b0, 16'h0);
    end
    chk("wrcount_random", wr_count, cnt_m);

    // Reset while presenting a sample; RAM must survive.
    rd_base = 8'd10; rd_len = 9'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_wrcount", wr_count, 0);
    @(negedge clk);
    reset = 1'b0;
    cnt_m = 0;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    play(8'd10, 9'd5, 1, -1, 0, 1'b0, 1'b0, 16'h0);
    chk("post_rst_wrcount", wr_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
